ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding for the 5-stage core; sits directly upstream of the ALU.
//  - Captures decoded ID fields each cycle and produces ALU operands A/B and alu_ctrl.
//  - Forwards results from EX/MEM and MEM/WB, and detects load-use hazards.
//  - Inserts bubbles on load-use and on branch flush.
// PARAMETERS
//  XLEN      32  datapath width (ALU operands, register data)
//  REG_AW    5   register address width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  id_valid       in   1      ID holds a real instruction
//  id_pc          in   XLEN   PC of ID instruction
//  id_rs1_addr    in   REG_AW rs1 index
//  id_rs2_addr    in   REG_AW rs2 index
//  id_rd_addr     in   REG_AW rd index
//  id_rs1_data    in   XLEN   regfile rs1 read data
//  id_rs2_data    in   XLEN   regfile rs2 read data
//  id_imm         in   XLEN   sign-extended immediate
//  id_alu_src_pc  in   1      A = pc (AUIPC/JAL) instead of rs1
//  id_alu_src_imm in   1      B = imm instead of rs2
//  id_alu_ctrl    in   4      ALU opcode (ADD 0000, SUB 0001, AND 0010, OR 0100, XOR 1000, SRL 1001, SLL 1010, SRA 1100, BUF 1101)
//  id_reg_write   in   1      instruction writes rd
//  id_mem_read    in   1      instruction is a load
//  id_mem_write   in   1      instruction is a store
//  flush          in   1      branch/jump taken in EX; kill ID instruction
//  exm_rd_addr    in   REG_AW EX/MEM destination
//  exm_reg_write  in   1      EX/MEM writes rd
//  exm_result     in   XLEN   EX/MEM ALU result
//  mwb_rd_addr    in   REG_AW MEM/WB destination
//  mwb_reg_write  in   1      MEM/WB writes rd
//  mwb_data       in   XLEN   MEM/WB writeback data
//  id_stall       out  1      hold PC and IF/ID this cycle (combinational)
//  alu_a          out  XLEN   ALU operand A
//  alu_b          out  XLEN   ALU operand B
//  alu_ctrl       out  4      registered ALU opcode
//  ex_store_data  out  XLEN   forwarded rs2 for stores
//  ex_rd_addr     out  REG_AW registered rd
//  ex_valid       out  1      EX holds a real instruction
//  ex_reg_write   out  1      registered reg_write, gated by valid
//  ex_mem_read    out  1      registered mem_read, gated by valid
//  ex_mem_write   out  1      registered mem_write, gated by valid
//  stall_count    out  32     bubble counter (only with STALL_CNT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all registered fields 0.
//    ex_valid/ex_reg_write/ex_mem_read/ex_mem_write = 0; alu_ctrl = 4'b0000 (ADD); stall_count = 0.
//    With these values, alu_a = alu_b = 0.
//  - Load-use: id_stall = ex_valid & ex_mem_read & id_valid & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
//    Match is checked on rs2 even for immediate-form instructions (conservative).
//  - Per-edge priority:
//    1. flush -> bubble
//    2. id_stall -> bubble
//    3. else capture ID fields; ex_valid <= id_valid.
//    Bubble = valid and all control bits 0, alu_ctrl ADD, data fields 0.
//    flush and id_stall both asserted -> bubble, counted once.
//  - Forwarding (combinational from registered rs1/rs2 data), per operand:
//    if exm_reg_write & exm_rd_addr != 0 & match -> exm_result;
//    else if mwb_reg_write & mwb_rd_addr != 0 & match -> mwb_data;
//    else registered regfile data. EX/MEM wins over MEM/WB; x0 is never forwarded.
//  - Operand select:
//    alu_a = src_pc ? pc : fwd_rs1
//    alu_b = src_imm ? imm : fwd_rs2
//    ex_store_data = fwd_rs2 always.
//  - Latency: 1 cycle ID->EX register; id_stall asserts in the same cycle as the hazard.
//    A stall lasts exactly 1 cycle, because the bubble clears ex_mem_read.
//  - Reset mid-operation: in-flight instruction is dropped; id_stall deasserts immediately.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_count increments by 1 (wrapping at 2^32-1 -> 0) on every edge that loads a bubble due to flush or id_stall.
//  STALL_CNT_EN undefined: counter logic is omitted and stall_count is tied to 0.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> all outputs 0 asynchronously; alu_ctrl=0000; id_stall=0.
//  2. EX/MEM forward: EX holds rs1=5; exm_rd=5, exm_reg_write=1, exm_result=0x1234; mwb_rd=5, mwb_data=0xBEEF -> alu_a=0x1234.
//  3. x0 guard: rs2=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF, regfile rs2=0 -> alu_b=0.
//  4. Load-use: EX load to x7, ID uses rs1=7 -> id_stall=1 for one cycle, next ex_valid=0, following cycle instruction captured; stall_count +1 (if enabled).
//  5. Flush+stall: both high on the same edge -> one bubble, ex_reg_write=0, stall_count +1 only.
//  6. Operand select: AUIPC pc=0x100, imm=0x2000, ctrl ADD -> alu_a=0x100, alu_b=0x2000. LUI: BUF with imm=0xABCDE000 -> alu_b=0xABCDE000.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use detection.
// Optional bubble counter enabled by defining STALL_CNT_EN.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src_pc,
    input  logic              id_alu_src_imm,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_data,
    output logic              id_stall,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [31:0]       stall_count
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              src_pc;
        logic              src_imm;
        logic [3:0]        alu_ctrl;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            bubble;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // rs2 is compared even for immediate forms; a spare stall is harmless
    assign id_stall = ex_q.valid & ex_q.mem_read & id_valid
                    & (ex_q.rd_addr != '0)
                    & ((ex_q.rd_addr == id_rs1_addr)
                     | (ex_q.rd_addr == id_rs2_addr));

    assign bubble = flush | id_stall;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.src_pc    = id_alu_src_pc;
            ex_d.src_imm   = id_alu_src_imm;
            ex_d.alu_ctrl  = id_alu_ctrl;
            ex_d.reg_write = id_valid & id_reg_write;
            ex_d.mem_read  = id_valid & id_mem_read;
            ex_d.mem_write = id_valid & id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it takes precedence
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (exm_reg_write && exm_rd_addr != '0
            && exm_rd_addr == ex_q.rs1_addr) begin
            fwd_rs1 = exm_result;
        end else if (mwb_reg_write && mwb_rd_addr != '0
                     && mwb_rd_addr == ex_q.rs1_addr) begin
            fwd_rs1 = mwb_data;
        end
    end

    always_comb begin
        fwd_rs2 = ex_q.rs2_data;
        if (exm_reg_write && exm_rd_addr != '0
            && exm_rd_addr == ex_q.rs2_addr) begin
            fwd_rs2 = exm_result;
        end else if (mwb_reg_write && mwb_rd_addr != '0
                     && mwb_rd_addr == ex_q.rs2_addr) begin
            fwd_rs2 = mwb_data;
        end
    end

    assign alu_a         = ex_q.src_pc  ? ex_q.pc  : fwd_rs1;
    assign alu_b         = ex_q.src_imm ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

`ifdef STALL_CNT_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (bubble) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: forwarding/operand table through a scoreboard,
// plus hand sequences for reset, load-use, flush and flush+stall.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_alu_src_pc;
    logic        id_alu_src_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;
    logic [4:0]  exm_rd_addr;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  mwb_rd_addr;
    logic        mwb_reg_write;
    logic [31:0] mwb_data;
    logic        id_stall;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] stall_count;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm),
        .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
        .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write),
        .exm_result(exm_result),
        .mwb_rd_addr(mwb_rd_addr), .mwb_reg_write(mwb_reg_write),
        .mwb_data(mwb_data),
        .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        spc;
        logic        simm;
        logic [3:0]  ctrl;
        logic        rw;
        logic        mw;
        logic [4:0]  erd;
        logic        erw;
        logic [31:0] eres;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mdat;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [31:0] ctl;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    vec_t v[8];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic valid, input logic [31:0] pc,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
        input logic spc, input logic simm, input logic [3:0] ctrl,
        input logic rw, input logic mw,
        input logic [4:0] erd, input logic erw, input logic [31:0] eres,
        input logic [4:0] mrd, input logic mrw, input logic [31:0] mdat,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es);
        vec_t r;
        r.valid = valid; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.d1 = d1; r.d2 = d2; r.imm = imm; r.spc = spc; r.simm = simm;
        r.ctrl = ctrl; r.rw = rw; r.mw = mw;
        r.erd = erd; r.erw = erw; r.eres = eres;
        r.mrd = mrd; r.mrw = mrw; r.mdat = mdat;
        r.ea = ea; r.eb = eb; r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef STALL_CNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rd_addr = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_alu_src_pc = 0; id_alu_src_imm = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
        exm_rd_addr = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd_addr = 0; mwb_reg_write = 0; mwb_data = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [3:0] ctrl);
        idle();
        id_valid = 1; id_rd_addr = rd; id_mem_read = 1;
        id_reg_write = 1; id_alu_ctrl = ctrl; id_alu_src_imm = 1;
    endtask

    initial begin
        exp_t e;
        v[0] = mk(1, 32'h40, 5, 6, 3, 32'h11, 32'h22, 0, 0, 0, 4'b0000, 1, 0,
                  5, 1, 32'h1234, 5, 1, 32'hBEEF, 32'h1234, 32'h22, 32'h22);
        v[1] = mk(1, 32'h44, 8, 9, 12, 32'h1, 32'h2, 0, 0, 0, 4'b0001, 1, 0,
                  8, 0, 32'hDEAD, 9, 1, 32'h55, 32'h1, 32'h55, 32'h55);
        v[2] = mk(1, 32'h48, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0001, 1, 0,
                  0, 1, 32'hFFFF, 0, 1, 32'hAAAA, 0, 0, 0);
        v[3] = mk(1, 32'h100, 0, 0, 2, 0, 0, 32'h2000, 1, 1, 4'b0000, 1, 0,
                  0, 0, 0, 0, 0, 0, 32'h100, 32'h2000, 0);
        v[4] = mk(1, 32'h104, 0, 0, 3, 0, 0, 32'hABCDE000, 0, 1, 4'b1101, 1, 0,
                  0, 0, 0, 0, 0, 0, 0, 32'hABCDE000, 0);
        v[5] = mk(1, 32'h108, 2, 4, 0, 32'h1000, 32'h77, 32'h8, 0, 1, 4'b0000, 0, 1,
                  4, 1, 32'h999, 2, 1, 32'h2000, 32'h2000, 32'h8, 32'h999);
        v[6] = mk(0, 32'h10C, 1, 1, 5, 32'h3, 32'h4, 0, 0, 0, 4'b1010, 1, 0,
                  0, 0, 0, 0, 0, 0, 32'h3, 32'h4, 32'h4);
        v[7] = mk(1, 32'h110, 11, 10, 6, 32'h7, 32'h5, 0, 0, 0, 4'b1100, 1, 0,
                  10, 0, 32'h9, 10, 1, 32'h66, 32'h7, 32'h66, 32'h66);

        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_ctl", {19'b0, ex_valid, ex_reg_write, ex_mem_read,
                        ex_mem_write, alu_ctrl, ex_rd_addr}, 0);
        chk("rst_stall", {31'b0, id_stall}, 0);
        chk("rst_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle();
            id_valid = v[i].valid; id_pc = v[i].pc;
            id_rs1_addr = v[i].rs1; id_rs2_addr = v[i].rs2;
            id_rd_addr = v[i].rd;
            id_rs1_data = v[i].d1; id_rs2_data = v[i].d2;
            id_imm = v[i].imm;
            id_alu_src_pc = v[i].spc; id_alu_src_imm = v[i].simm;
            id_alu_ctrl = v[i].ctrl;
            id_reg_write = v[i].rw; id_mem_write = v[i].mw;
            e.a = v[i].ea; e.b = v[i].eb; e.s = v[i].es;
            e.ctl = {19'b0, v[i].valid, v[i].valid & v[i].rw, 1'b0,
                     v[i].valid & v[i].mw, v[i].ctrl, v[i].rd};
            sb.push_back(e);
            @(posedge clk);
            #1;
            exm_rd_addr = v[i].erd; exm_reg_write = v[i].erw;
            exm_result = v[i].eres;
            mwb_rd_addr = v[i].mrd; mwb_reg_write = v[i].mrw;
            mwb_data = v[i].mdat;
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_alu_a", i), alu_a, e.a);
                chk($sformatf("v%0d_alu_b", i), alu_b, e.b);
                chk($sformatf("v%0d_store", i), ex_store_data, e.s);
                chk($sformatf("v%0d_ctl", i),
                    {19'b0, ex_valid, ex_reg_write, ex_mem_read,
                     ex_mem_write, alu_ctrl, ex_rd_addr}, e.ctl);
            end
        end

        // load-use: one bubble, then the dependent instruction enters EX
        @(negedge clk);
        drive_load(7, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rs2_addr = 3; id_rd_addr = 9;
        id_reg_write = 1;
        #1;
        chk("lu_stall", {31'b0, id_stall}, 1);
        @(posedge clk);
        exp_cnt++;
        #1;
        chk("lu_bubble_valid", {31'b0, ex_valid}, 0);
        chk("lu_bubble_mr", {31'b0, ex_mem_read}, 0);
        chk("lu_stall_drop", {31'b0, id_stall}, 0);
        chk("lu_count", stall_count, exp_count());
        @(posedge clk);
        #1;
        chk("lu_capture", {26'b0, ex_valid, ex_reg_write, ex_rd_addr},
            {26'b0, 1'b1, 1'b1, 5'd9});

        // flush and stall together: one bubble, counted once
        @(negedge clk);
        drive_load(7, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        idle();
        id_valid = 1; id_rs2_addr = 7; id_rd_addr = 4; id_reg_write = 1;
        id_alu_src_imm = 1; flush = 1;
        #1;
        chk("fs_stall", {31'b0, id_stall}, 1);
        @(posedge clk);
        exp_cnt++;
        #1;
        chk("fs_valid", {31'b0, ex_valid}, 0);
        chk("fs_rw", {31'b0, ex_reg_write}, 0);
        chk("fs_alu_a", alu_a, 0);
        chk("fs_count", stall_count, exp_count());

        // flush alone
        @(negedge clk);
        idle();
        id_valid = 1; id_rd_addr = 3; id_reg_write = 1; flush = 1;
        @(posedge clk);
        exp_cnt++;
        #1;
        chk("fl_valid", {31'b0, ex_valid}, 0);
        chk("fl_count", stall_count, exp_count());

        // async reset while a load sits in EX and ID is stalled on it
        @(negedge clk);
        drive_load(7, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rd_addr = 2; id_reg_write = 1;
        #1;
        chk("mr_stall_pre", {31'b0, id_stall}, 1);
        #2;
        rst_n = 0;
        exp_cnt = 0;
        #1;
        chk("mr_stall", {31'b0, id_stall}, 0);
        chk("mr_ctl", {19'b0, ex_valid, ex_reg_write, ex_mem_read,
                       ex_mem_write, alu_ctrl, ex_rd_addr}, 0);
        chk("mr_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1;
        idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
